framebuffer_arbiter: RTL and testbench

- Upstream stage of the APA102 LED output engine.
- Owns the single-port 16-bit pixel RAM, e.g. an SPRAM block.
- Serves two clients:
  - Read port: the LED output engine, which issues read_address/read_request and consumes read_data plus read_finished_strobe.
  - Write port: the host-side pixel loader.
- Arbitrates the single RAM port between the two clients and returns read data with a one-cycle completion strobe.

---
 rtl/framebuffer_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// -----------------------------------------------------------------------------
// framebuffer_arbiter
//
// Upstream stage of the APA102 LED output engine. Owns the single-port 16-bit
// pixel RAM and shares its one port between the LED engine (read client) and
// the host pixel loader (write client).
//
// Optional feature macro: FRAMEBUFFER_DOUBLE_BUFFER_EN
//   defined   : two banks; writes go to the draw bank (~display_bank) and
//               swap_strobe exchanges banks at the next idle cycle.
//   undefined : single bank 0; swap_strobe ignored, display_bank fixed at 0.
//
// Ports
//   clk                  system clock, all logic on posedge
//   rst                  asynchronous, active-low reset
//   read_address/request word address + level request from the LED engine
//   read_data            returned pixel word, held between strobes
//   read_finished_strobe one-cycle pulse, read_data valid in that cycle
//   write_address/data   host word address and pixel word
//   write_request        level request, held until write_ack
//   write_ack            one-cycle pulse in the cycle the RAM write happens
//   swap_strobe          one-cycle bank-exchange request
//   display_bank         bank currently served to the read port
//   mem_address          RAM address, MSB is the bank bit
//   mem_data_in          RAM write data
//   mem_write_enable     RAM write strobe
//   mem_data_out         RAM read data (MEM_LATENCY cycles after address)
//   state_debug          current arbiter state (IDLE=0, READ_WAIT=1,
//                        READ_DONE=2, WRITE=3)
//
// Handshake: both clients present a level request with stable address/data.
// A request is accepted only in IDLE; the address is latched at the grant, so
// later changes on the client bus are ignored. Completion is signalled by a
// one-cycle pulse (read_finished_strobe / write_ack); a request dropped
// while the arbiter is still in IDLE is simply never granted.
// -----------------------------------------------------------------------------
module framebuffer_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int MEM_LATENCY       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0] read_address,
    input  logic                         read_request,
    output logic [15:0]                  read_data,
    output logic                         read_finished_strobe,
    input  logic [ADDRESS_BUS_WIDTH-1:0] write_address,
    input  logic [15:0]                  write_data,
    input  logic                         write_request,
    output logic                         write_ack,
    input  logic                         swap_strobe,
    output logic                         display_bank,
    output logic [ADDRESS_BUS_WIDTH:0]   mem_address,
    output logic [15:0]                  mem_data_in,
    output logic                         mem_write_enable,
    input  logic [15:0]                  mem_data_out,
    output logic [1:0]                   state_debug
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        READ_DONE = 2'd2,
        WRITE     = 2'd3
    } state_t;

    // Counter value in the last READ_WAIT cycle; mem_data_out is captured
    // on the edge that ends that cycle.
    localparam logic [1:0] LAST_COUNT = 2'(MEM_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] latency_count;
    logic       priority_bit;   // 0: read wins a tie, 1: write wins a tie
    logic       grant_read;
    logic       grant_write;
    logic       contended;
    logic       read_last;
    logic       draw_bank;

    assign state_debug = state;

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        grant_read  = 1'b0;
        grant_write = 1'b0;
        contended   = 1'b0;
        read_last   = 1'b0;
        case (state)
            IDLE: begin
                if (read_request && write_request) begin
                    contended = 1'b1;
                    if (priority_bit) grant_write = 1'b1;
                    else              grant_read  = 1'b1;
                end else if (read_request) begin
                    grant_read = 1'b1;
                end else if (write_request) begin
                    grant_write = 1'b1;
                end
                if (grant_read)  state_next = READ_WAIT;
                if (grant_write) state_next = WRITE;
            end
            READ_WAIT: begin
                if (latency_count == LAST_COUNT) begin
                    read_last  = 1'b1;
                    state_next = READ_DONE;
                end
            end
            // Mandatory gap so the downstream FIFO full flag settles before
            // read_request is looked at again.
            READ_DONE: state_next = IDLE;
            WRITE:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            latency_count        <= 2'd0;
            priority_bit         <= 1'b0;
            read_data            <= 16'd0;
            read_finished_strobe <= 1'b0;
            write_ack            <= 1'b0;
            mem_address          <= '0;
            mem_data_in          <= 16'd0;
            mem_write_enable     <= 1'b0;
        end else begin
            state <= state_next;

            // Only a tie flips the priority; lone grants leave it alone.
            if (contended) priority_bit <= ~priority_bit;

            if (grant_read)              latency_count <= 2'd0;
            else if (state == READ_WAIT) latency_count <= latency_count + 2'd1;

            read_finished_strobe <= read_last;
            if (read_last) read_data <= mem_data_out;

            // Write strobe and acknowledge are the same registered pulse, so
            // the ack marks exactly the cycle the RAM sees the write.
            mem_write_enable <= grant_write;
            write_ack        <= grant_write;

            if (grant_read) begin
                mem_address <= {display_bank, read_address};
            end else if (grant_write) begin
                mem_address <= {draw_bank, write_address};
                mem_data_in <= write_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank selection
    // ------------------------------------------------------------------
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    logic swap_pending;
    logic swap_now;

    // A swap only lands in an IDLE cycle that grants nothing, so it can
    // never split a read or a write.
    assign swap_now  = (state == IDLE) && !grant_read && !grant_write;
    assign draw_bank = ~display_bank;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            display_bank <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_pending && swap_now) begin
            display_bank <= ~display_bank;
            swap_pending <= 1'b0;
        end else if (swap_strobe) begin
            // Setting an already-set flag absorbs repeated requests.
            swap_pending <= 1'b1;
        end
    end
`else
    logic unused_swap;

    assign unused_swap  = swap_strobe;
    assign draw_bank    = 1'b0;
    assign display_bank = 1'b0;
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for framebuffer_arbiter. A behavioural RAM sits on the memory port;
// expected read values come from a separate model memory that the bench
// updates from its own write requests, and expected timing comes from the
// documented latencies (read: MEM_LATENCY+1, write ack: next cycle).
// -----------------------------------------------------------------------------
module tb_framebuffer_arbiter;

    localparam int AW     = 16;
    localparam int LAT    = 2;
    localparam int SR_IDX = (LAT > 1) ? LAT - 2 : 0;
    localparam int DEPTH  = 1 << (AW + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] read_address;
    logic          read_request;
    logic [15:0]   read_data;
    logic          read_finished_strobe;
    logic [AW-1:0] write_address;
    logic [15:0]   write_data;
    logic          write_request;
    logic          write_ack;
    logic          swap_strobe;
    logic          display_bank;
    logic [AW:0]   mem_address;
    logic [15:0]   mem_data_in;
    logic          mem_write_enable;
    logic [15:0]   mem_data_out;
    logic [1:0]    state_debug;

    framebuffer_arbiter #(
        .ADDRESS_BUS_WIDTH (AW),
        .MEM_LATENCY       (LAT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .read_address         (read_address),
        .read_request         (read_request),
        .read_data            (read_data),
        .read_finished_strobe (read_finished_strobe),
        .write_address        (write_address),
        .write_data           (write_data),
        .write_request        (write_request),
        .write_ack            (write_ack),
        .swap_strobe          (swap_strobe),
        .display_bank         (display_bank),
        .mem_address          (mem_address),
        .mem_data_in          (mem_data_in),
        .mem_write_enable     (mem_write_enable),
        .mem_data_out         (mem_data_out),
        .state_debug          (state_debug)
    );

    // ---------------- behavioural RAM ----------------
    logic [15:0] ram [0:DEPTH-1];
    logic [AW:0] addr_sr [0:2];
    logic [AW:0] rd_addr;

    always @(posedge clk) begin
        addr_sr[0] <= mem_address;
        addr_sr[1] <= addr_sr[0];
        addr_sr[2] <= addr_sr[1];
        if (mem_write_enable) ram[mem_address] <= mem_data_in;
    end
    assign rd_addr      = (LAT == 1) ? mem_address : addr_sr[SR_IDX];
    assign mem_data_out = ram[rd_addr];

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] model_mem [0:DEPTH-1];
    logic        exp_db;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          total;
    int          bad;
    int          overlap;

    always @(negedge clk) begin
        if (rst && mem_write_enable && read_finished_strobe) overlap++;
    end

    function automatic logic [15:0] init_word(int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    function automatic logic draw_of(logic db);
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        return ~db;
`else
        return 1'b0 & db;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        read_request = 1'b0; write_request = 1'b0; swap_strobe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick;
        exp_db = 1'b0;
    endtask

    // Issues one read from IDLE; returns cycles to strobe (-1 on timeout).
    // Ends in the IDLE cycle following READ_DONE.
    task automatic do_read(input logic [AW-1:0] addr, output int lat,
                           output logic [15:0] data, output logic [AW:0] maddr);
        lat = -1; data = '0; maddr = '0;
        read_address = addr;
        read_request = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (c == 1) read_request = 1'b0;
            if (read_finished_strobe) begin
                lat = c; data = read_data; maddr = mem_address;
                break;
            end
        end
        read_request = 1'b0;
        tick;
    endtask

    // Issues one write from IDLE; samples the ack cycle and the cycle after.
    task automatic do_write(input logic [AW-1:0] addr, input logic [15:0] data,
                            output int lat, output logic we_at_ack,
                            output logic [AW:0] maddr, output logic [15:0] mdata,
                            output logic tail);
        lat = -1; we_at_ack = 1'b0; maddr = '0; mdata = '0;
        write_address = addr;
        write_data    = data;
        write_request = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (write_ack) begin
                lat = c; we_at_ack = mem_write_enable;
                maddr = mem_address; mdata = mem_data_in;
                break;
            end
        end
        write_request = 1'b0;
        tick;
        tail = write_ack | mem_write_enable;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [52:0] snap;
        #1;
        snap = {read_data, read_finished_strobe, write_ack, display_bank,
                mem_address, mem_data_in, mem_write_enable};
        total++;
        if (snap !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", snap);
        end
        @(negedge clk);
        rst = 1'b1;
        tick;
        exp_db = 1'b0;
    endtask

    task automatic test_read_latency;
        int          sc[$];
        logic [15:0] sd[$];
        logic [15:0] e0, e1;
        e0 = model_mem[{exp_db, 16'h0010}];
        e1 = model_mem[{exp_db, 16'h0011}];
        read_address = 16'h0010;
        read_request = 1'b1;
        for (int c = 1; c <= 2 * LAT + 4; c++) begin
            tick;
            if (c == 1) read_address = 16'h0011;
            if (read_finished_strobe) begin sc.push_back(c); sd.push_back(read_data); end
            if (c == 2 * LAT + 3) read_request = 1'b0;
        end
        total++;
        if (sc.size() != 2) begin
            bad++; $display("FAIL latency_count got=%0d want=2", sc.size());
        end else begin
            total++;
            if (sc[0] != LAT + 1) begin bad++; $display("FAIL latency_first got=%0d want=%0d", sc[0], LAT + 1); end
            total++;
            if (sd[0] !== e0) begin bad++; $display("FAIL latency_data0 got=%h want=%h", sd[0], e0); end
            total++;
            if (sc[1] != 2 * LAT + 3) begin bad++; $display("FAIL latency_second got=%0d want=%0d", sc[1], 2 * LAT + 3); end
            total++;
            if (sd[1] !== e1) begin bad++; $display("FAIL latency_data1 got=%h want=%h", sd[1], e1); end
        end
    endtask

    task automatic test_write_readback;
        int lat; logic we; logic [AW:0] ma; logic [15:0] md; logic tail;
        logic [15:0] rd; logic [AW:0] rma;
        do_write(16'h0020, 16'h1234, lat, we, ma, md, tail);
        model_mem[{draw_of(exp_db), 16'h0020}] = 16'h1234;
        total++;
        if (lat != 1 || we !== 1'b1) begin bad++; $display("FAIL write_ack lat=%0d we=%b want lat=1 we=1", lat, we); end
        total++;
        if (ma !== {draw_of(exp_db), 16'h0020} || md !== 16'h1234) begin
            bad++; $display("FAIL write_bus addr=%h data=%h want %h/1234", ma, md, {draw_of(exp_db), 16'h0020});
        end
        total++;
        if (tail !== 1'b0) begin bad++; $display("FAIL write_single_cycle got=%b want=0", tail); end
        do_read(16'h0020, lat, rd, rma);
        total++;
        if (lat != LAT + 1 || rd !== model_mem[{exp_db, 16'h0020}]) begin
            bad++; $display("FAIL write_readback lat=%0d data=%h want %0d/%h", lat, rd, LAT + 1, model_mem[{exp_db, 16'h0020}]);
        end
    endtask

    task automatic test_reset_mid_read;
        int lat; logic we; logic [AW:0] ma; logic [15:0] md; logic tail;
        logic [15:0] rd; logic [52:0] snap;
        do_write(16'h0040, 16'h55AA, lat, we, ma, md, tail);
        model_mem[{draw_of(exp_db), 16'h0040}] = 16'h55AA;
        do_read(16'h0010, lat, rd, ma);
        read_address = 16'h0007;
        read_request = 1'b1;
        tick;
        #2 rst = 1'b0;
        #1;
        snap = {read_data, read_finished_strobe, write_ack, display_bank,
                mem_address, mem_data_in, mem_write_enable};
        total++;
        if (snap !== '0) begin bad++; $display("FAIL reset_mid_read got=%h want=0", snap); end
        @(negedge clk);
        read_request = 1'b0;
        rst = 1'b1;
        tick;
        exp_db = 1'b0;
        do_read(16'h0005, lat, rd, ma);
        total++;
        if (lat != LAT + 1 || rd !== model_mem[{1'b0, 16'h0005}]) begin
            bad++; $display("FAIL after_reset_read lat=%0d data=%h want %0d/%h", lat, rd, LAT + 1, model_mem[{1'b0, 16'h0005}]);
        end
    endtask

    task automatic test_request_drop;
        int n;
        n = 0;
        read_address = 16'h0003;
        read_request = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (c == 1) read_request = 1'b0;
            if (read_finished_strobe) n++;
        end
        total++;
        if (n != 1) begin bad++; $display("FAIL request_drop strobes=%0d want=1", n); end
    endtask

    task automatic test_contention;
        int nr, nw, extra;
        do_reset;
        nr = 0; nw = 0; extra = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 8'h52 : 8'h57);
        read_address  = 16'h0031;
        write_address = 16'h0030;
        write_data    = 16'h7777;
        read_request  = 1'b1;
        write_request = 1'b1;
        for (int c = 0; c < 80 && got_q.size() < 8; c++) begin
            tick;
            if (read_finished_strobe) begin got_q.push_back(8'h52); nr++; end
            if (write_ack)            begin got_q.push_back(8'h57); nw++; end
        end
        read_request = 1'b0;
        write_request = 1'b0;
        model_mem[{draw_of(exp_db), 16'h0030}] = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (read_finished_strobe || write_ack) extra++;
        end
        total++;
        if (got_q.size() != 8) begin
            bad++; $display("FAIL contention_events got=%0d want=8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL contention_order[%0d] got=%c want=%c", i, got_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (nr != 4 || nw != 4 || extra != 0) begin
            bad++; $display("FAIL contention_counts reads=%0d writes=%0d extra=%0d want 4/4/0", nr, nw, extra);
        end
    endtask

    task automatic test_random;
        int lat; logic we; logic [AW:0] ma; logic [15:0] md; logic tail;
        logic [AW-1:0] a; logic [15:0] d; logic [15:0] rd;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                do_write(a, d, lat, we, ma, md, tail);
                total++;
                if (lat != 1 || we !== 1'b1 || tail !== 1'b0 ||
                    ma !== {draw_of(exp_db), a} || md !== d) begin
                    bad++; $display("FAIL rand_write[%0d] lat=%0d we=%b tail=%b addr=%h data=%h want addr=%h data=%h",
                                    i, lat, we, tail, ma, md, {draw_of(exp_db), a}, d);
                end
                model_mem[{draw_of(exp_db), a}] = d;
            end else begin
                do_read(a, lat, rd, ma);
                total++;
                if (lat != LAT + 1 || rd !== model_mem[{exp_db, a}] || ma !== {exp_db, a}) begin
                    bad++; $display("FAIL rand_read[%0d] lat=%0d data=%h addr=%h want %0d/%h/%h",
                                    i, lat, rd, ma, LAT + 1, model_mem[{exp_db, a}], {exp_db, a});
                end
            end
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    task automatic test_bank_swap;
        int lat, toggles, early; logic we; logic [AW:0] ma; logic [15:0] md; logic tail;
        logic [15:0] rd; logic old, prev;
        old = exp_db;
        toggles = 0; early = 0;
        do_write(16'h0000, 16'hBEEF, lat, we, ma, md, tail);
        model_mem[{draw_of(exp_db), 16'h0000}] = 16'hBEEF;
        prev = display_bank;
        read_address = 16'h0001;
        read_request = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (display_bank !== prev) toggles++;
            prev = display_bank;
            if (c <= LAT + 1 && display_bank !== old) early++;
            read_request = 1'b0;
            swap_strobe  = (c == 1 || c == LAT + 1);
        end
        swap_strobe = 1'b0;
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
        exp_db = ~old;
        total++;
        if (toggles != 1 || early != 0 || display_bank !== exp_db) begin
            bad++; $display("FAIL bank_swap toggles=%0d early=%0d bank=%b want 1/0/%b", toggles, early, display_bank, exp_db);
        end
        do_read(16'h0000, lat, rd, ma);
        total++;
        if (lat != LAT + 1 || rd !== 16'hBEEF || ma !== {exp_db, 16'h0000}) begin
            bad++; $display("FAIL bank_swap_read lat=%0d data=%h addr=%h want %0d/beef/%h", lat, rd, ma, LAT + 1, {exp_db, 16'h0000});
        end
`else
        total++;
        if (toggles != 0 || display_bank !== 1'b0) begin
            bad++; $display("FAIL bank_fixed toggles=%0d bank=%b want 0/0", toggles, display_bank);
        end
        do_read(16'h0000, lat, rd, ma);
        total++;
        if (rd !== 16'hBEEF || ma[AW] !== 1'b0) begin
            bad++; $display("FAIL bank_shared data=%h msb=%b want beef/0", rd, ma[AW]);
        end
`endif
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        total = 0; bad = 0; overlap = 0; exp_db = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]       = init_word(i);
            model_mem[i] = init_word(i);
        end
        ram[17'h00010]       = 16'hA5C3;
        model_mem[17'h00010] = 16'hA5C3;
        rst = 1'b0;
        read_address = '0; read_request = 1'b0;
        write_address = '0; write_data = '0; write_request = 1'b0;
        swap_strobe = 1'b0;

        test_reset;
        test_read_latency;
        test_write_readback;
        test_reset_mid_read;
        test_request_drop;
        test_contention;
        test_random;
        test_bank_swap;

        total++;
        if (overlap != 0) begin bad++; $display("FAIL we_strobe_overlap got=%0d want=0", overlap); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
